// File: rtl/call_stack_pkg.sv
// Shared sizing and control-decode types for the return-address stack.
// The datapath PC mux also imports this package for CS_AW/CS_PTR_W.
package call_stack_pkg;

    localparam int CS_DEPTH = 16;
    localparam int CS_AW    = 32;
    localparam int CS_PTR_W = $clog2(CS_DEPTH) + 1;

    // Raw requests from the control unit for one cycle.
    typedef struct packed {
        logic push;
        logic pop;
        logic err_clr;
    } cs_ctrl_t;

    // Resolved operation for one cycle.
    typedef struct packed {
        logic wr;   // write ret_addr into storage
        logic rd;   // pop the top entry into pop_addr
        logic inc;  // count + 1
        logic dec;  // count - 1
        logic ovf;  // overflow event
        logic unf;  // underflow event
    } cs_op_t;

    // Push with pop on a non-empty stack is a swap, so a full stack only
    // refuses a lone push; a pop on an empty stack is always refused.
    function automatic cs_op_t cs_decode(input cs_ctrl_t ctrl,
                                         input logic     full,
                                         input logic     empty);
        cs_op_t op;
        op.wr  = ctrl.push && (!full || ctrl.pop);
        op.rd  = ctrl.pop && !empty;
        op.inc = op.wr && !op.rd;
        op.dec = op.rd && !op.wr;
        op.ovf = ctrl.push && full && !ctrl.pop;
        op.unf = ctrl.pop && empty;
        return op;
    endfunction

endpackage

// File: rtl/call_stack_mem.sv
// Return-address storage: DEPTH x AW registers, one write port and an
// asynchronous read port. Contents are not reset.
module call_stack_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [AW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [AW-1:0]            rdata
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware call stack: pointer, pop register and sticky error flags around
// call_stack_mem. Push+pop on a non-empty stack swaps the top entry.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int DEPTH = CS_DEPTH,
    parameter int AW    = CS_AW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [AW-1:0]          ret_addr,
    input  logic                   err_clr,
    output logic [AW-1:0]          pop_addr,
    output logic                   pop_valid,
    output logic [AW-1:0]          top_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    cs_ctrl_t         ctrl;
    cs_op_t           op;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [AW-1:0]    rd_data;

    assign full  = (count == PTR_W'(DEPTH));
    assign empty = (count == '0);

    assign ctrl = '{push: push, pop: pop, err_clr: err_clr};
    assign op   = cs_decode(ctrl, full, empty);

    // Low bits of count-1; at count==DEPTH the low bits are zero and the
    // subtraction lands on DEPTH-1 as required.
    assign top_idx = count[IDX_W-1:0] - IDX_W'(1);
    assign wr_idx  = op.rd ? top_idx : count[IDX_W-1:0];

    call_stack_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (op.wr && reset),
        .waddr (wr_idx),
        .wdata (ret_addr),
        .raddr (top_idx),
        .rdata (rd_data)
    );

    // Stale storage beyond count must never leak out.
    assign top_addr = empty ? '0 : rd_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= '0;
            pop_addr  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= op.rd;
            if (op.rd)
                pop_addr <= rd_data;
            if (op.inc)
                count <= count + PTR_W'(1);
            else if (op.dec)
                count <= count - PTR_W'(1);
            // A new error event wins over a same-cycle clear.
            overflow  <= op.ovf || (overflow  && !err_clr);
            underflow <= op.unf || (underflow && !err_clr);
        end
    end

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_call_stack;
    localparam int DEPTH = 16;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset, push, pop, err_clr;
    logic [AW-1:0] ret_addr;
    logic [AW-1:0] pop_addr, top_addr;
    logic          pop_valid, full, empty, overflow, underflow;
    logic [4:0]    count;

    int n_vec = 0;
    int n_err = 0;

    // reference model
    logic [AW-1:0] m_stk[$];
    logic [AW-1:0] m_pop_addr;
    logic          m_pop_valid, m_ovf, m_unf;

    always #5 clk = ~clk;

    call_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .ret_addr(ret_addr),
        .err_clr(err_clr), .pop_addr(pop_addr), .pop_valid(pop_valid),
        .top_addr(top_addr), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    // Apply one cycle of inputs, advance the model, sample 1ns after the edge.
    task automatic step(input logic rst, input logic ps, input logic pp,
                        input logic [AW-1:0] a, input logic clr);
        logic ev_o, ev_u;
        @(negedge clk);
        reset = rst; push = ps; pop = pp; ret_addr = a; err_clr = clr;
        @(posedge clk);
        #1;
        if (!rst) begin
            m_stk.delete();
            m_pop_addr = '0; m_pop_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            ev_o = ps && !pp && (m_stk.size() == DEPTH);
            ev_u = pp && (m_stk.size() == 0);
            m_pop_valid = 1'b0;
            if (pp && m_stk.size() > 0) begin
                m_pop_addr  = m_stk.pop_back();
                m_pop_valid = 1'b1;
                if (ps) m_stk.push_back(a);
            end else if (ps && m_stk.size() < DEPTH) begin
                m_stk.push_back(a);
            end
            if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
            if (ev_o) m_ovf = 1'b1;
            if (ev_u) m_unf = 1'b1;
        end
        @(negedge clk);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0; reset = 1'b1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b1);
        n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_vec++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_empty_full got=%b%b exp=10", empty, full); end
        n_vec++; if (top_addr !== '0) begin n_err++; $display("FAIL reset_top got=%h exp=0", top_addr); end
        n_vec++; if (pop_addr !== '0 || pop_valid !== 1'b0) begin n_err++; $display("FAIL reset_pop got=%h/%b exp=0/0", pop_addr, pop_valid); end
        n_vec++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); end
    endtask

    task automatic test_lifo();
        logic [AW-1:0] exp_q[3];
        exp_q = '{32'h30, 32'h20, 32'h10};
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h10, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h20, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h30, 1'b0);
        n_vec++; if (count !== 5'd3) begin n_err++; $display("FAIL lifo_count got=%0d exp=3", count); end
        n_vec++; if (top_addr !== 32'h30) begin n_err++; $display("FAIL lifo_top got=%h exp=30", top_addr); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, '0, 1'b0);
            n_vec++; if (pop_addr !== exp_q[i] || pop_valid !== 1'b1) begin n_err++; $display("FAIL lifo_pop%0d got=%h/%b exp=%h/1", i, pop_addr, pop_valid, exp_q[i]); end
        end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL lifo_empty got=%b exp=1", empty); end
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        n_vec++; if (pop_valid !== 1'b0 || pop_addr !== 32'h10) begin n_err++; $display("FAIL lifo_idle got=%h/%b exp=10/0", pop_addr, pop_valid); end
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 32'h100 + i, 1'b0);
        n_vec++; if (full !== 1'b1 || overflow !== 1'b0) begin n_err++; $display("FAIL ovf_prefull got=%b%b exp=10", full, overflow); end
        step(1'b1, 1'b1, 1'b0, 32'h999, 1'b0);
        n_vec++; if (full !== 1'b1 || overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b%b exp=11", full, overflow); end
        n_vec++; if (count !== 5'd16 || top_addr !== 32'h10F) begin n_err++; $display("FAIL ovf_state got=%0d/%h exp=16/10f", count, top_addr); end
        // clear and set in the same cycle: set wins
        step(1'b1, 1'b1, 1'b0, 32'h998, 1'b1);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_setwins got=%b exp=1", overflow); end
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_full_swap();
        // continues from a full stack
        step(1'b1, 1'b1, 1'b1, 32'h777, 1'b0);
        n_vec++; if (pop_addr !== 32'h10F || pop_valid !== 1'b1) begin n_err++; $display("FAIL fswap_pop got=%h/%b exp=10f/1", pop_addr, pop_valid); end
        n_vec++; if (count !== 5'd16 || overflow !== 1'b0 || top_addr !== 32'h777) begin n_err++; $display("FAIL fswap_state got=%0d/%b/%h exp=16/0/777", count, overflow, top_addr); end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b1, '0, 1'b0);
        n_vec++; if (underflow !== 1'b1 || pop_valid !== 1'b0) begin n_err++; $display("FAIL unf_flag got=%b/%b exp=1/0", underflow, pop_valid); end
        n_vec++; if (count !== 5'd0 || pop_addr !== '0) begin n_err++; $display("FAIL unf_state got=%0d/%h exp=0/0", count, pop_addr); end
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL unf_clr got=%b exp=0", underflow); end
        // push+pop on empty: push only, underflow set, no pulse
        step(1'b1, 1'b1, 1'b1, 32'h55, 1'b0);
        n_vec++; if (count !== 5'd1 || underflow !== 1'b1 || pop_valid !== 1'b0 || top_addr !== 32'h55) begin n_err++; $display("FAIL unf_pushpop got=%0d/%b/%b/%h exp=1/1/0/55", count, underflow, pop_valid, top_addr); end
    endtask

    task automatic test_swap();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'hA, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'hB, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'hC, 1'b0);
        n_vec++; if (pop_addr !== 32'hB || pop_valid !== 1'b1) begin n_err++; $display("FAIL swap_pop got=%h/%b exp=b/1", pop_addr, pop_valid); end
        n_vec++; if (top_addr !== 32'hC || count !== 5'd2) begin n_err++; $display("FAIL swap_state got=%h/%0d exp=c/2", top_addr, count); end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h40 + i, 1'b0);
        n_vec++; if (count !== 5'd5) begin n_err++; $display("FAIL rmid_pre got=%0d exp=5", count); end
        step(1'b0, 1'b1, 1'b0, 32'hEE, 1'b0);
        n_vec++; if (count !== 5'd0 || empty !== 1'b1 || top_addr !== '0 || pop_valid !== 1'b0) begin n_err++; $display("FAIL rmid_post got=%0d/%b/%h/%b exp=0/1/0/0", count, empty, top_addr, pop_valid); end
    endtask

    task automatic test_random();
        logic          rr, ps, pp, cl;
        logic [AW-1:0] a;
        logic [AW-1:0] m_top;
        int            bias;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            bias = ((i / 100) % 2 == 0) ? 75 : 30;  // alternate fill/drain phases
            rr = ($urandom_range(0, 199) != 0);
            ps = ($urandom_range(0, 99) < bias);
            pp = ($urandom_range(0, 99) < (100 - bias));
            cl = ($urandom_range(0, 15) == 0);
            a  = $urandom;
            step(rr, ps, pp, a, cl);
            m_top = (m_stk.size() > 0) ? m_stk[$] : '0;
            n_vec++;
            if (count !== 5'(m_stk.size()) || top_addr !== m_top || pop_valid !== m_pop_valid ||
                pop_addr !== m_pop_addr || overflow !== m_ovf || underflow !== m_unf ||
                full !== (m_stk.size() == DEPTH) || empty !== (m_stk.size() == 0)) begin
                n_err++;
                $display("FAIL rand%0d got cnt=%0d top=%h pv=%b pa=%h o=%b u=%b f=%b e=%b exp cnt=%0d top=%h pv=%b pa=%h o=%b u=%b",
                         i, count, top_addr, pop_valid, pop_addr, overflow, underflow, full, empty,
                         m_stk.size(), m_top, m_pop_valid, m_pop_addr, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; ret_addr = '0;
        m_pop_addr = '0; m_pop_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        test_reset();
        test_lifo();
        test_overflow();
        test_full_swap();
        test_underflow();
        test_swap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
